// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP: state encoding, data-register select
// and the default instruction opcodes.
package jtag_pkg;

    localparam int IR_LEN_DEF = 4;

    localparam logic [3:0] OP_IDCODE_DEF      = 4'h1;
    localparam logic [3:0] OP_GPIO_DATA_DEF   = 4'h2;
    localparam logic [3:0] OP_GPIO_CONFIG_DEF = 4'h3;

    // Encoding follows the usual 1149.1 reference numbering.
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_GPIO   = 2'd2
    } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register, TMS-driven next-state logic and
// Moore strobes decoded from the registered state.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       reset_,
    input  logic       tms,
    output tap_state_e state,
    output logic       test_logic_reset,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr
);

    tap_state_e state_q, state_d;

    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        state_d = tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR        : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    always_comb begin
        state            = state_q;
        test_logic_reset = (state_q == TEST_LOGIC_RESET);
        capture_dr       = (state_q == CAPTURE_DR);
        shift_dr         = (state_q == SHIFT_DR);
        update_dr        = (state_q == UPDATE_DR);
    end

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP with IR, BYPASS and GPIO chain routing; the IDCODE register and
// opcode exist only when JTAG_TAP_IDCODE_EN is defined.
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int                 IR_LEN         = IR_LEN_DEF,
    parameter logic [31:0]        IDCODE_VALUE   = 32'h0001_2345,
    parameter logic [IR_LEN-1:0]  OP_IDCODE      = IR_LEN'(OP_IDCODE_DEF),
    parameter logic [IR_LEN-1:0]  OP_GPIO_DATA   = IR_LEN'(OP_GPIO_DATA_DEF),
    parameter logic [IR_LEN-1:0]  OP_GPIO_CONFIG = IR_LEN'(OP_GPIO_CONFIG_DEF),
    parameter logic [IR_LEN-1:0]  OP_BYPASS      = {IR_LEN{1'b1}}
) (
    input  logic tck,
    input  logic reset_,
    input  logic tms,
    input  logic tdi,
    input  logic gpios_tdo,
    output logic tdo,
    output logic tdo_ena,
    output logic test_logic_reset,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic gpio_data_ir,
    output logic gpio_config_ir
);

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_LEN-1:0] RESET_IR = OP_IDCODE;
`else
    localparam logic [IR_LEN-1:0] RESET_IR = OP_BYPASS;
`endif

    tap_state_e state;

    jtag_tap_fsm u_fsm (
        .tck              (tck),
        .reset_           (reset_),
        .tms              (tms),
        .state            (state),
        .test_logic_reset (test_logic_reset),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr)
    );

    logic capture_ir, shift_ir, update_ir;

    always_comb begin
        capture_ir = (state == CAPTURE_IR);
        shift_ir   = (state == SHIFT_IR);
        update_ir  = (state == UPDATE_IR);
    end

    logic [IR_LEN-1:0] ir_q, ir_d;
    logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
    logic              bypass_q, bypass_d;
    logic              tdo_q, tdo_d;
    logic              tdo_ena_q, tdo_ena_d;
    dr_sel_e           dr_sel;

    // Unrecognised opcodes fall through to BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == OP_GPIO_DATA || ir_q == OP_GPIO_CONFIG) begin
            dr_sel = DR_GPIO;
        end
`ifdef JTAG_TAP_IDCODE_EN
        else if (ir_q == OP_IDCODE) begin
            dr_sel = DR_IDCODE;
        end
`endif
    end

    always_comb begin
        gpio_data_ir   = (ir_q == OP_GPIO_DATA);
        gpio_config_ir = (ir_q == OP_GPIO_CONFIG);
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        if (capture_ir) begin
            ir_shift_d = IR_LEN'(1);
        end else if (shift_ir) begin
            ir_shift_d = {tdi, ir_shift_q[IR_LEN-1:1]};
        end

        ir_d = ir_q;
        if (test_logic_reset) begin
            ir_d = RESET_IR;
        end else if (update_ir) begin
            ir_d = ir_shift_q;
        end

        bypass_d = bypass_q;
        if (dr_sel == DR_BYPASS) begin
            if (capture_dr) begin
                bypass_d = 1'b0;
            end else if (shift_dr) begin
                bypass_d = tdi;
            end
        end
    end

    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            ir_q       <= RESET_IR;
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
        end
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_q, idcode_d;

    always_comb begin
        idcode_d = idcode_q;
        if (dr_sel == DR_IDCODE) begin
            if (capture_dr) begin
                idcode_d = IDCODE_VALUE;
            end else if (shift_dr) begin
                idcode_d = {tdi, idcode_q[31:1]};
            end
        end
    end

    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            idcode_q <= IDCODE_VALUE;
        end else begin
            idcode_q <= idcode_d;
        end
    end
`endif

    always_comb begin
        tdo_d     = 1'b0;
        tdo_ena_d = 1'b0;
        if (shift_ir) begin
            tdo_d     = ir_shift_q[0];
            tdo_ena_d = 1'b1;
        end else if (shift_dr) begin
            tdo_ena_d = 1'b1;
            case (dr_sel)
                DR_GPIO:   tdo_d = gpios_tdo;
`ifdef JTAG_TAP_IDCODE_EN
                DR_IDCODE: tdo_d = idcode_q[0];
`endif
                default:   tdo_d = bypass_q;
            endcase
        end
    end

    // Falling-edge retiming gives the downstream device a half cycle of setup.
    always_ff @(negedge tck or negedge reset_) begin
        if (!reset_) begin
            tdo_q     <= 1'b0;
            tdo_ena_q <= 1'b0;
        end else begin
            tdo_q     <= tdo_d;
            tdo_ena_q <= tdo_ena_d;
        end
    end

    assign tdo     = tdo_q;
    assign tdo_ena = tdo_ena_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Directed-plus-random bench for jtag_tap; expected TDO streams come from a
// queue-based delay-line model of the selected data register.
module tb_jtag_tap;

    localparam logic [31:0] IDCODE_V = 32'h0001_2345;
    localparam logic [3:0]  OP_IDC   = 4'h1;
    localparam logic [3:0]  OP_GD    = 4'h2;
    localparam logic [3:0]  OP_GC    = 4'h3;
    localparam logic [3:0]  OP_BYP   = 4'hF;
`ifdef JTAG_TAP_IDCODE_EN
    localparam bit IDCODE_EN = 1'b1;
`else
    localparam bit IDCODE_EN = 1'b0;
`endif

    logic tck       = 1'b0;
    logic reset_    = 1'b1;
    logic tms       = 1'b1;
    logic tdi       = 1'b0;
    logic gpios_tdo = 1'b0;
    logic tdo, tdo_ena, test_logic_reset, capture_dr, shift_dr, update_dr;
    logic gpio_data_ir, gpio_config_ir;

    jtag_tap dut (
        .tck              (tck),
        .reset_           (reset_),
        .tms              (tms),
        .tdi              (tdi),
        .gpios_tdo        (gpios_tdo),
        .tdo              (tdo),
        .tdo_ena          (tdo_ena),
        .test_logic_reset (test_logic_reset),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .gpio_data_ir     (gpio_data_ir),
        .gpio_config_ir   (gpio_config_ir)
    );

    // ---------------- clock ----------------
    always #5 tck = ~tck;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [0:0] exp_q[$];
    logic [3:0] reset_op;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0 = bypass, 1 = idcode, 2 = gpio chain
    function automatic int dr_kind(input logic [3:0] op);
        if (op == OP_GD || op == OP_GC) return 2;
        if (IDCODE_EN && op == OP_IDC) return 1;
        return 0;
    endfunction

    // ---------------- driver tasks ----------------
    // Samples tdo for the current state, then applies tms/tdi for the next posedge.
    task automatic step(input logic t, input logic d, output logic tdo_s, output logic ena_s);
        @(negedge tck);
        #1;
        tdo_s     = tdo;
        ena_s     = tdo_ena;
        tms       = t;
        tdi       = d;
        gpios_tdo = 1'($urandom_range(0, 1));
        @(posedge tck);
    endtask

    task automatic load_ir(input logic [3:0] op);
        logic s_tdo, s_ena;
        logic [3:0] cap;
        cap = 4'b0001;
        step(1'b1, 1'b0, s_tdo, s_ena);
        step(1'b1, 1'b0, s_tdo, s_ena);
        step(1'b0, 1'b0, s_tdo, s_ena);
        step(1'b0, 1'b0, s_tdo, s_ena);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, op[i], s_tdo, s_ena);
            chk("ir_capture_tdo", {31'd0, s_tdo}, {31'd0, cap[i]});
            chk("ir_shift_ena", {31'd0, s_ena}, 32'd1);
        end
        step(1'b1, 1'b0, s_tdo, s_ena);
        step(1'b0, 1'b0, s_tdo, s_ena);
        #1;
        chk("gpio_data_ir", {31'd0, gpio_data_ir}, {31'd0, op == OP_GD});
        chk("gpio_config_ir", {31'd0, gpio_config_ir}, {31'd0, op == OP_GC});
    endtask

    // Starts and ends in RUN_TEST_IDLE.
    task automatic dr_scan(input logic [3:0] op, input int n, input logic [63:0] pat);
        logic s_tdo, s_ena, g, e;
        logic [31:0] idv;
        int kind;
        idv  = IDCODE_V;
        kind = dr_kind(op);
        exp_q.delete();
        if (kind == 1) begin
            for (int i = 0; i < 32; i++) exp_q.push_back(idv[i]);
        end else begin
            exp_q.push_back(1'b0);
        end
        step(1'b1, 1'b0, s_tdo, s_ena);
        step(1'b0, 1'b0, s_tdo, s_ena);
        #1;
        chk("capture_dr", {31'd0, capture_dr}, 32'd1);
        step(1'b0, 1'b0, s_tdo, s_ena);
        #1;
        chk("shift_dr", {31'd0, shift_dr}, 32'd1);
        chk("capture_dr_once", {31'd0, capture_dr}, 32'd0);
        for (int i = 0; i < n; i++) begin
            g = gpios_tdo;
            step(i == n - 1, pat[i], s_tdo, s_ena);
            if (kind == 2) begin
                e = g;
            end else begin
                e = exp_q.pop_front();
                exp_q.push_back(pat[i]);
            end
            chk("dr_tdo", {31'd0, s_tdo}, {31'd0, e});
            chk("dr_tdo_ena", {31'd0, s_ena}, 32'd1);
        end
        step(1'b1, 1'b0, s_tdo, s_ena);
        chk("exit1_ena", {31'd0, s_ena}, 32'd0);
        #1;
        chk("update_dr", {31'd0, update_dr}, 32'd1);
        chk("shift_dr_off", {31'd0, shift_dr}, 32'd0);
        step(1'b0, 1'b0, s_tdo, s_ena);
        chk("update_ena", {31'd0, s_ena}, 32'd0);
        #1;
        chk("update_dr_once", {31'd0, update_dr}, 32'd0);
        chk("dr_gpio_data_stable", {31'd0, gpio_data_ir}, {31'd0, op == OP_GD});
        chk("dr_gpio_config_stable", {31'd0, gpio_config_ir}, {31'd0, op == OP_GC});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tlr"}, {31'd0, test_logic_reset}, 32'd1);
        chk({tag, "_strobes"}, {29'd0, capture_dr, shift_dr, update_dr}, 32'd0);
        chk({tag, "_tdo"}, {30'd0, tdo, tdo_ena}, 32'd0);
        chk({tag, "_ir_dec"}, {30'd0, gpio_data_ir, gpio_config_ir}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic s_tdo, s_ena;
        logic [3:0] op;
        reset_op = IDCODE_EN ? OP_IDC : OP_BYP;

        #2 reset_ = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge tck);
        @(negedge tck);
        #1 reset_ = 1'b1;
        step(1'b0, 1'b0, s_tdo, s_ena);

        // Reset instruction: IDCODE stream, or BYPASS 0 followed by the shifted data.
        dr_scan(reset_op, 32, {$urandom, $urandom});

        load_ir(OP_GD);
        dr_scan(OP_GD, 8, 64'd0);
        load_ir(OP_GC);
        dr_scan(OP_GC, 8, 64'd0);

        load_ir(4'h5);
        dr_scan(4'h5, 5, 64'b01101);

        // From SHIFT_IR, five TMS ones must land in TEST_LOGIC_RESET.
        step(1'b1, 1'b0, s_tdo, s_ena);
        step(1'b1, 1'b0, s_tdo, s_ena);
        step(1'b0, 1'b0, s_tdo, s_ena);
        step(1'b0, 1'b0, s_tdo, s_ena);
        #1 chk("shift_ir_state_dr_off", {31'd0, shift_dr}, 32'd0);
        repeat (5) step(1'b1, 1'b1, s_tdo, s_ena);
        #1 chk("tms_reset_tlr", {31'd0, test_logic_reset}, 32'd1);
        chk("tms_reset_ir_dec", {30'd0, gpio_data_ir, gpio_config_ir}, 32'd0);
        step(1'b0, 1'b0, s_tdo, s_ena);
        #1 chk("rti_tlr_low", {31'd0, test_logic_reset}, 32'd0);
        dr_scan(reset_op, 32, {32'd0, 32'hFFFF_FFFF});

        for (int k = 0; k < 12; k++) begin
            op = 4'($urandom_range(0, 15));
            load_ir(op);
            dr_scan(op, int'($urandom_range(1, 40)), {$urandom, $urandom});
        end

        // Asynchronous reset in the middle of a DR shift.
        load_ir(OP_GD);
        step(1'b1, 1'b0, s_tdo, s_ena);
        step(1'b0, 1'b0, s_tdo, s_ena);
        step(1'b0, 1'b0, s_tdo, s_ena);
        #6;
        chk("mid_shift_ena", {30'd0, shift_dr, tdo_ena}, 32'd3);
        reset_ = 1'b0;
        #1 check_reset_outputs("async");
        @(negedge tck);
        #1 reset_ = 1'b1;
        step(1'b0, 1'b0, s_tdo, s_ena);
        dr_scan(reset_op, 34, {$urandom, $urandom});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
